// File: rtl/de0_nano_system_led_ctrl.sv
// Avalon-MM LED/GPIO output controller with atomic set/clear and optional per-bit blinking.
// Blinking (BLINK, PERIOD, STATUS, prescaler) is built only when DE0_NANO_LED_CTRL_BLINK_EN is defined.
module de0_nano_system_led_ctrl #(
  parameter int unsigned             WIDTH       = 8,
  parameter int unsigned             PERIOD_W    = 24,
  parameter logic [WIDTH-1:0]        RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  logic             wr_s;
  logic [WIDTH-1:0] wd_data_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_s;

  assign wr_s      = chipselect && !write_n;
  assign wd_data_s = writedata[WIDTH-1:0];

  // Next DATA value from direct, set and clear writes.
  always_comb begin
    data_s = data_r;
    if (wr_s) begin
      case (address)
        3'd0:    data_s = wd_data_s;
        3'd1:    data_s = data_r | wd_data_s;
        3'd2:    data_s = data_r & ~wd_data_s;
        default: data_s = data_r;
      endcase
    end else begin
      data_s = data_r;
    end
  end

`ifdef DE0_NANO_LED_CTRL_BLINK_EN
  localparam logic [PERIOD_W-1:0] PERIOD_ZERO = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] PERIOD_ONE  = PERIOD_W'(1);

  logic [WIDTH-1:0]    blink_r;
  logic [WIDTH-1:0]    blink_s;
  logic [PERIOD_W-1:0] period_r;
  logic [PERIOD_W-1:0] period_s;
  logic [PERIOD_W-1:0] cnt_r;
  logic [PERIOD_W-1:0] cnt_s;
  logic                phase_r;
  logic                phase_s;
  logic                period_wr_s;

  assign period_wr_s = wr_s && (address == 3'd4);

  // Next BLINK/PERIOD and prescaler state; a PERIOD write restarts the half-period with phase high.
  always_comb begin
    blink_s  = blink_r;
    period_s = period_r;
    cnt_s    = cnt_r;
    phase_s  = phase_r;
    if (wr_s && (address == 3'd3)) begin
      blink_s = wd_data_s;
    end else begin
      blink_s = blink_r;
    end
    if (period_wr_s) begin
      period_s = writedata[PERIOD_W-1:0];
      cnt_s    = writedata[PERIOD_W-1:0];
      phase_s  = 1'b1;
    end else if (period_r == PERIOD_ZERO) begin
      cnt_s   = PERIOD_ZERO;
      phase_s = 1'b1;
    end else if (cnt_r == PERIOD_ZERO) begin
      cnt_s   = period_r;
      phase_s = ~phase_r;
    end else begin
      cnt_s   = cnt_r - PERIOD_ONE;
      phase_s = phase_r;
    end
  end

  // Register state; out_port is derived from next-state values so it changes cleanly on the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_r   <= RESET_VALUE;
      blink_r  <= {WIDTH{1'b0}};
      period_r <= PERIOD_ZERO;
      cnt_r    <= PERIOD_ZERO;
      phase_r  <= 1'b1;
      out_port <= RESET_VALUE;
    end else begin
      data_r   <= data_s;
      blink_r  <= blink_s;
      period_r <= period_s;
      cnt_r    <= cnt_s;
      phase_r  <= phase_s;
      out_port <= data_s & ~(blink_s & {WIDTH{~phase_s}});
    end
  end

  // Zero-latency read mux; unused upper bits read as zero.
  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0, 3'd1, 3'd2: readdata[WIDTH-1:0]    = data_r;
      3'd3:             readdata[WIDTH-1:0]    = blink_r;
      3'd4:             readdata[PERIOD_W-1:0] = period_r;
      3'd5:             readdata[0]            = phase_r;
      default:          readdata               = 32'd0;
    endcase
  end
`else
  // Register DATA; out_port mirrors it directly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_r   <= RESET_VALUE;
      out_port <= RESET_VALUE;
    end else begin
      data_r   <= data_s;
      out_port <= data_s;
    end
  end

  // Zero-latency read mux; only the DATA aliases return nonzero values.
  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0, 3'd1, 3'd2: readdata[WIDTH-1:0] = data_r;
      default:          readdata            = 32'd0;
    endcase
  end
`endif

endmodule

// File: doc/de0_nano_system_led_ctrl.md
# de0_nano_system_led_ctrl

Parametrised Avalon-MM LED/GPIO output controller on the system interconnect. It replaces the fixed 8-bit single-register output port with:
- a configurable width;
- atomic set and clear registers, so software needs no read-modify-write;
- per-bit hardware blinking driven by a programmable prescaler.

Zero-wait-state slave; `out_port` drives board LEDs directly.

## Interface
Parameters:
- `WIDTH`, 8 — output port width, 1..32.
- `PERIOD_W`, 24 — prescaler/period register width, 1..32.
- `RESET_VALUE`, 0 — `WIDTH`-bit reset value of the DATA register.

Ports:
- `clk`  in  1  — single clock for all logic.
- `reset_n`  in  1  — reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `address`  in  3  — word address.
- `chipselect`  in  1  — slave select.
- `write_n`  in  1  — active-low write strobe.
- `writedata`  in  32  — write data.
- `readdata`  out  32  — read data, combinational from `address`.
- `out_port`  out  `WIDTH`  — LED drive.

## Operation
- A write occurs when `chipselect && !write_n`. Bits above `WIDTH` (or `PERIOD_W`) are ignored on write and read as 0.
- Register map:
  - 0 DATA, RW: output data.
  - 1 OUTSET, W: DATA |= wd. Reads return DATA.
  - 2 OUTCLR, W: DATA &= ~wd. Reads return DATA.
  - 3 BLINK, RW: per-bit blink enable.
  - 4 PERIOD, RW: half-period reload value.
  - 5 STATUS, R: bit0 = `phase`; bits[31:1] = 0.
  - 6–7: reads return 0; writes are ignored.
- Prescaler:
  - `cnt` is a `PERIOD_W`-bit down-counter; `phase` is a 1-bit register.
  - If PERIOD == 0: `cnt` holds at 0 and `phase` is forced to 1, so blinking bits show DATA steadily.
  - Else, each cycle:
    - if `cnt` == 0: `phase` toggles and `cnt` loads PERIOD;
    - otherwise `cnt` decrements.
  - Half-period is PERIOD+1 cycles.
- A write to PERIOD loads `cnt` with the new value and sets `phase` to 1 in the same edge. This overrides any expiry in that cycle.
- Output: `out_port` = DATA & ~(BLINK & {WIDTH{~phase}}). Bits with BLINK=0 follow DATA; bits with BLINK=1 show DATA while `phase`=1 and 0 while `phase`=0.
- `out_port` is a registered output: it is computed from next-state values so that it is glitch-free.
- Writes to BLINK or DATA do not disturb `cnt` or `phase`. A counter expiry in the same cycle as a BLINK or DATA write applies both.

## Timing
- Reset, while `reset_n`=0 at a `clk` edge:
  - DATA=`RESET_VALUE`; BLINK=0; PERIOD=0; `cnt`=0; `phase`=1.
  - `out_port`=`RESET_VALUE`; `readdata` reflects the reset registers.
- Reset asserted mid-period discards the count. After deassertion, blinking stays off until PERIOD is written.
- Write latency: the register updates at the write edge; `out_port` shows the effect at the same edge (one cycle after the write is presented).
- Read latency 0: `readdata` is valid in the same cycle `address` is presented. `chipselect` is not required for read data.
- Blink: with PERIOD=P≠0 written at edge t0, `phase`=1 for edges t0..t0+P. It toggles to 0 at edge t0+P+1 and back to 1 at t0+2P+2.
- Saturation: PERIOD = 2^PERIOD_W−1 is legal. No wrap hazard exists, since `cnt` only decrements from nonzero values.

## Configuration
- `DE0_NANO_LED_CTRL_BLINK_EN` defined: BLINK, PERIOD, STATUS, the prescaler and the masking are present as described above.
- Not defined:
  - The prescaler logic is removed.
  - Addresses 3, 4 and 5 read 0 and ignore writes.
  - `out_port` = DATA.
  - DATA, OUTSET and OUTCLR are unchanged.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `RESET_VALUE`=8'hA5 → `out_port`=8'hA5, read addr 5 = 1, read addr 4 = 0.
- Set/clear: write DATA=8'h0F, then OUTSET=8'h30, then OUTCLR=8'h05 → `out_port` sequence 0F, 3F, 3A; read addr 1 = 8'h3A; upper readdata bits 0.
- Blink: DATA=8'hFF, BLINK=8'h81, PERIOD=3 → bits 7 and 0 are high for 4 cycles and low for 4 cycles, repeating; bits 6:1 stay high constantly.
- PERIOD rewrite mid-period: PERIOD=10; after 5 cycles write PERIOD=2 → `phase` forced to 1 at that edge, first toggle 3 cycles later.
- Period 0 / collision: with blinking active, write PERIOD=0 → `out_port`=DATA steady. Separately, write BLINK on the exact expiry cycle → both the toggle and the new mask apply at that edge.
- Synchronous reset mid-blink with `phase`=0 → next edge `out_port`=`RESET_VALUE`. Build without `DE0_NANO_LED_CTRL_BLINK_EN` → writes to addr 3/4 have no effect and read 0.
